// File: rtl/net_tx_queue_if.sv
// Messenger-side capture and link-side flit signals of net_tx_queue.
// The slave modport is the queue itself; the master modport is its environment.
interface net_tx_queue_if #(
    parameter int unsigned AW = 2
);
    logic          NETSEND;
    logic          NETTYPE;
    logic [79:0]   NETMSG;
    logic [4:0]    NETSTAT;
    logic          NETRDY;
    logic          TXVALID;
    logic [15:0]   TXDATA;
    logic          TXSOP;
    logic          TXEOP;
    logic          TXREADY;
    logic [AW:0]   QLEVEL;
    logic          OVF;
    logic          OVFCLR;

    modport slave (
        input  NETSEND, NETTYPE, NETMSG, NETSTAT, TXREADY, OVFCLR,
        output NETRDY, TXVALID, TXDATA, TXSOP, TXEOP, QLEVEL, OVF
    );

    modport master (
        output NETSEND, NETTYPE, NETMSG, NETSTAT, TXREADY, OVFCLR,
        input  NETRDY, TXVALID, TXDATA, TXSOP, TXEOP, QLEVEL, OVF
    );
endinterface

// File: rtl/net_tx_queue.sv
// Transmit message queue: FIFO plus one-entry overflow stage, serialised into framed 16-bit flits.
// Optional NET_TX_PARITY_EN appends an XOR check flit to every frame.
module net_tx_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input logic          CLK,
    input logic          RESET,
    net_tx_queue_if.slave bus
);
`ifdef NET_TX_PARITY_EN
    typedef enum logic [1:0] {StIdle, StHdr, StData, StChk} state_t;
`else
    typedef enum logic [1:0] {StIdle, StHdr, StData} state_t;
`endif

    logic [85:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          stage_v_q;
    logic [85:0]   stage_q;
    logic          netrdy_q, ovf_q;
    state_t        state_q, state_d;
    logic [2:0]    k_q, k_d, k_nxt;
    logic [6:0]    base;
    logic [85:0]   out_q, out_d, head, wdata;
    logic          tx_valid_q, tx_valid_d, tx_sop_q, tx_sop_d, tx_eop_q, tx_eop_d;
    logic [15:0]   tx_data_q, tx_data_d;
    logic          full, drain, push, pop, stage_load, overflow;

    // Stage drains ahead of a new message; a message arriving alongside refills it.
    always_comb begin
        full       = (count_q == (AW + 1)'(DEPTH));
        drain      = stage_v_q && !full;
        push       = drain || (bus.NETSEND && !stage_v_q && !full);
        wdata      = drain ? stage_q : {bus.NETTYPE, bus.NETSTAT, bus.NETMSG};
        stage_load = bus.NETSEND && (drain || (!stage_v_q && full));
        overflow   = bus.NETSEND && stage_v_q && full;
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            stage_v_q <= 1'b0;
            stage_q   <= '0;
            netrdy_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
            if (stage_load) stage_q <= {bus.NETTYPE, bus.NETSTAT, bus.NETMSG};
            if (stage_load)   stage_v_q <= 1'b1;
            else if (drain)   stage_v_q <= 1'b0;
            netrdy_q <= push;
            if (overflow)        ovf_q <= 1'b1;
            else if (bus.OVFCLR) ovf_q <= 1'b0;
        end
    end

`ifdef NET_TX_PARITY_EN
    logic [15:0] parity;
    always_comb begin
        parity = {out_q[85:80], 10'd0} ^ out_q[15:0] ^ out_q[31:16] ^ out_q[47:32]
               ^ out_q[63:48] ^ out_q[79:64];
    end
`endif

    // Outputs are registered: each branch loads the flit to be shown in the next state.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        out_d      = out_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_sop_d   = tx_sop_q;
        tx_eop_d   = tx_eop_q;
        pop        = 1'b0;
        head       = mem[rd_ptr_q];
        k_nxt      = k_q + 3'd1;
        base       = {k_nxt, 4'b0000};
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    out_d      = head;
                    k_d        = 3'd0;
                    state_d    = StHdr;
                    tx_valid_d = 1'b1;
                    tx_sop_d   = 1'b1;
                    tx_eop_d   = 1'b0;
                    tx_data_d  = {head[85:80], 10'd0};
                end
            end
            StHdr: begin
                if (bus.TXREADY) begin
                    state_d   = StData;
                    k_d       = 3'd0;
                    tx_sop_d  = 1'b0;
                    tx_data_d = out_q[15:0];
                end
            end
            StData: begin
                if (bus.TXREADY) begin
                    if (k_q == 3'd4) begin
`ifdef NET_TX_PARITY_EN
                        state_d   = StChk;
                        tx_data_d = parity;
                        tx_eop_d  = 1'b1;
`else
                        state_d    = StIdle;
                        tx_valid_d = 1'b0;
                        tx_eop_d   = 1'b0;
`endif
                    end else begin
                        k_d       = k_nxt;
                        tx_data_d = out_q[base +: 16];
`ifdef NET_TX_PARITY_EN
                        tx_eop_d  = 1'b0;
`else
                        tx_eop_d  = (k_q == 3'd3);
`endif
                    end
                end
            end
`ifdef NET_TX_PARITY_EN
            StChk: begin
                if (bus.TXREADY) begin
                    state_d    = StIdle;
                    tx_valid_d = 1'b0;
                    tx_eop_d   = 1'b0;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= StIdle;
            k_q        <= '0;
            out_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_sop_q   <= 1'b0;
            tx_eop_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            out_q      <= out_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_sop_q   <= tx_sop_d;
            tx_eop_q   <= tx_eop_d;
        end
    end

    assign bus.NETRDY  = netrdy_q;
    assign bus.TXVALID = tx_valid_q;
    assign bus.TXDATA  = tx_data_q;
    assign bus.TXSOP   = tx_sop_q;
    assign bus.TXEOP   = tx_eop_q;
    assign bus.QLEVEL  = count_q;
    assign bus.OVF     = ovf_q;
endmodule

// File: tb/tb_net_tx_queue.sv
// Randomised and directed bench for net_tx_queue against a message-level queue model.
module tb_net_tx_queue;
    localparam int DEPTH = 4;
`ifdef NET_TX_PARITY_EN
    localparam int NF = 7;
`else
    localparam int NF = 6;
`endif
    typedef logic [85:0] entry_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    net_tx_queue_if #(.AW(2)) bus ();
    net_tx_queue #(.DEPTH(DEPTH), .AW(2)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    int checks = 0;
    int failures = 0;

    // Model: a queue of accepted messages, an optional staged message, and the frame on the link.
    entry_t      m_q[$];
    int          m_cnt;
    bit          m_stage_v;
    entry_t      m_stage;
    bit          m_busy;
    int          m_idx;
    logic [15:0] m_fl[7];
    bit          m_rdy, m_ovf;
    logic [15:0] acc[$];

    task automatic model_reset();
        m_q.delete(); m_cnt = 0; m_stage_v = 0; m_stage = '0;
        m_busy = 0; m_idx = 0; m_rdy = 0; m_ovf = 0;
    endtask

    task automatic build_frame(input entry_t e);
        m_fl[0] = {e[85:80], 10'd0};
        for (int j = 0; j < 5; j++) m_fl[j+1] = e[16*j +: 16];
        m_fl[6] = m_fl[0] ^ m_fl[1] ^ m_fl[2] ^ m_fl[3] ^ m_fl[4] ^ m_fl[5];
    endtask

    task automatic cycle(input bit snd, input bit typ, input logic [4:0] st,
                         input logic [79:0] msg, input bit rdy, input bit clr);
        entry_t e;
        bit full, drain, push, pop, ovfl;
        bus.NETSEND = snd; bus.NETTYPE = typ; bus.NETSTAT = st; bus.NETMSG = msg;
        bus.TXREADY = rdy; bus.OVFCLR = clr;
        if (bus.TXVALID === 1'b1 && rdy) acc.push_back(bus.TXDATA);
        @(posedge CLK);
        e    = {typ, st, msg};
        full = (m_cnt == DEPTH);
        pop  = !m_busy && m_cnt > 0;
        if (m_busy && rdy) begin
            if (m_idx == NF - 1) m_busy = 0;
            else m_idx++;
        end
        if (pop) begin build_frame(m_q.pop_front()); m_busy = 1; m_idx = 0; end
        drain = m_stage_v && !full;
        push = 0; ovfl = 0;
        if (drain) begin
            m_q.push_back(m_stage); push = 1; m_stage_v = snd; m_stage = e;
        end else if (snd && !m_stage_v && !full) begin
            m_q.push_back(e); push = 1;
        end else if (snd && !m_stage_v) begin
            m_stage_v = 1; m_stage = e;
        end else if (snd) ovfl = 1;
        m_cnt = m_cnt + int'(push) - int'(pop);
        m_rdy = push;
        if (ovfl) m_ovf = 1;
        else if (clr) m_ovf = 0;
        #1;
        checks++;
        if (bus.NETRDY !== m_rdy) begin
            failures++; $display("FAIL netrdy t=%0t got=%b exp=%b", $time, bus.NETRDY, m_rdy);
        end
        checks++;
        if (bus.QLEVEL !== 3'(m_cnt)) begin
            failures++; $display("FAIL qlevel t=%0t got=%0d exp=%0d", $time, bus.QLEVEL, m_cnt);
        end
        checks++;
        if (bus.OVF !== m_ovf) begin
            failures++; $display("FAIL ovf t=%0t got=%b exp=%b", $time, bus.OVF, m_ovf);
        end
        checks++;
        if (bus.TXVALID !== m_busy) begin
            failures++; $display("FAIL txvalid t=%0t got=%b exp=%b", $time, bus.TXVALID, m_busy);
        end
        if (m_busy) begin
            checks++;
            if ({bus.TXDATA, bus.TXSOP, bus.TXEOP} !== {m_fl[m_idx], m_idx == 0, m_idx == NF - 1})
            begin
                failures++;
                $display("FAIL flit t=%0t got=%h/%b/%b exp=%h/%b/%b", $time, bus.TXDATA,
                         bus.TXSOP, bus.TXEOP, m_fl[m_idx], m_idx == 0, m_idx == NF - 1);
            end
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, 0, 5'd0, 80'd0, rdy, 0);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_reset();
        acc.delete();
    endtask

    task automatic test_reset();
        bus.NETSEND = 0; bus.NETTYPE = 0; bus.NETSTAT = 0; bus.NETMSG = 0;
        bus.TXREADY = 0; bus.OVFCLR = 0;
        RESET = 1'b1;
        #1;
        checks++;
        if ({bus.NETRDY, bus.TXVALID, bus.TXSOP, bus.TXEOP, bus.TXDATA, bus.QLEVEL, bus.OVF}
            !== 23'd0) begin
            failures++;
            $display("FAIL reset_state got=%b/%b/%b/%b/%h/%0d/%b exp=all zero", bus.NETRDY,
                     bus.TXVALID, bus.TXSOP, bus.TXEOP, bus.TXDATA, bus.QLEVEL, bus.OVF);
        end
        do_reset();
        idle(2, 1);
    endtask

    task automatic test_basic();
        logic [15:0] exp[6];
        exp[0] = 16'h0000; exp[1] = 16'h0007; exp[2] = 16'h0000;
        exp[3] = 16'h0042; exp[4] = 16'h5678; exp[5] = 16'h1234;
        acc.delete();
        cycle(1, 0, 5'd0, 80'h1234_5678_0042_0000_0007, 1, 0);
        checks++;
        if (bus.NETRDY !== 1'b1) begin
            failures++; $display("FAIL basic_netrdy got=%b exp=1", bus.NETRDY);
        end
        idle(NF + 3, 1);
        checks++;
        if (acc.size() != NF) begin
            failures++; $display("FAIL basic_count got=%0d exp=%0d", acc.size(), NF);
        end
        for (int i = 0; i < 6 && i < acc.size(); i++) begin
            checks++;
            if (acc[i] !== exp[i]) begin
                failures++; $display("FAIL basic_flit%0d got=%h exp=%h", i, acc[i], exp[i]);
            end
        end
    endtask

    task automatic test_status_hdr();
        acc.delete();
        cycle(1, 1, 5'h1F, 80'hDEAD_BEEF_0123_4567_89AB, 1, 0);
        idle(NF + 3, 1);
        checks++;
        if (acc.size() < 1 || acc[0] !== 16'hFC00) begin
            failures++;
            $display("FAIL status_hdr got=%h exp=fc00", acc.size() > 0 ? acc[0] : 16'hxxxx);
        end
    endtask

    task automatic test_overflow();
        logic [79:0] msgs[8];
        for (int i = 0; i < 8; i++) msgs[i] = 80'({$urandom(), $urandom(), $urandom()});
        acc.delete();
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 5'd0, msgs[i], 0, 0);
            idle(7, 0);
        end
        checks++;
        if (bus.QLEVEL !== 3'd4) begin
            failures++; $display("FAIL ovf_fill_level got=%0d exp=4", bus.QLEVEL);
        end
        cycle(1, 0, 5'd0, msgs[5], 0, 0);
        checks++;
        if (bus.NETRDY !== 1'b0) begin
            failures++; $display("FAIL ovf_stage_netrdy got=%b exp=0", bus.NETRDY);
        end
        idle(3, 0);
        cycle(1, 0, 5'd0, msgs[6], 0, 0);
        checks++;
        if (bus.OVF !== 1'b1) begin
            failures++; $display("FAIL ovf_set got=%b exp=1", bus.OVF);
        end
        cycle(1, 0, 5'd0, msgs[7], 0, 1);
        checks++;
        if (bus.OVF !== 1'b1) begin
            failures++; $display("FAIL ovf_set_wins got=%b exp=1", bus.OVF);
        end
        cycle(0, 0, 5'd0, 80'd0, 0, 1);
        checks++;
        if (bus.OVF !== 1'b0) begin
            failures++; $display("FAIL ovf_clear got=%b exp=0", bus.OVF);
        end
        idle(8 * NF + 12, 1);
        checks++;
        if (acc.size() != 6 * NF) begin
            failures++; $display("FAIL ovf_frames got=%0d exp=%0d", acc.size(), 6 * NF);
        end
        for (int f = 0; f < 6 && (f * NF + 1) < acc.size(); f++) begin
            checks++;
            if (acc[f * NF + 1] !== msgs[f][15:0]) begin
                failures++;
                $display("FAIL ovf_order%0d got=%h exp=%h", f, acc[f * NF + 1], msgs[f][15:0]);
            end
        end
    endtask

    task automatic test_toggle_ready();
        logic [79:0] msg;
        entry_t e;
        msg = 80'({$urandom(), $urandom(), $urandom()});
        e = {1'b1, 5'h0A, msg};
        acc.delete();
        cycle(1, 1, 5'h0A, msg, 0, 0);
        for (int i = 0; i < 4 * NF; i++) cycle(0, 0, 5'd0, 80'd0, i[0], 0);
        idle(2, 1);
        build_frame(e);
        checks++;
        if (acc.size() != NF) begin
            failures++; $display("FAIL toggle_count got=%0d exp=%0d", acc.size(), NF);
        end
        for (int i = 0; i < NF && i < acc.size(); i++) begin
            checks++;
            if (acc[i] !== m_fl[i]) begin
                failures++; $display("FAIL toggle_flit%0d got=%h exp=%h", i, acc[i], m_fl[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [79:0] msg;
        msg = 80'h0F0F_1111_2222_3333_4444;
        cycle(1, 0, 5'd0, 80'h5555_6666_7777_8888_9999, 1, 0);
        cycle(1, 0, 5'd0, 80'hAAAA_BBBB_CCCC_DDDD_EEEE, 1, 0);
        idle(3, 1);
        checks++;
        if (bus.TXDATA !== 16'h7777) begin
            failures++; $display("FAIL midframe_k2 got=%h exp=7777", bus.TXDATA);
        end
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (bus.TXVALID !== 1'b0 || bus.QLEVEL !== 3'd0) begin
            failures++;
            $display("FAIL async_reset got=%b/%0d exp=0/0", bus.TXVALID, bus.QLEVEL);
        end
        bus.NETSEND = 0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_reset();
        acc.delete();
        idle(2, 1);
        cycle(1, 0, 5'd0, msg, 1, 0);
        idle(NF + 3, 1);
        build_frame({6'd0, msg});
        checks++;
        if (acc.size() != NF || acc[NF - 1] !== m_fl[NF - 1] || acc[1] !== 16'h4444) begin
            failures++;
            $display("FAIL fresh_frame got=%0d flits exp=%0d", acc.size(), NF);
        end
    endtask

    task automatic test_random();
        int thr;
        for (int i = 0; i < 1800; i++) begin
            thr = (i / 300) % 3 == 0 ? 9 : ((i / 300) % 3 == 1 ? 4 : 1);
            cycle($urandom_range(0, 3) == 0, 1'($urandom()), 5'($urandom()),
                  80'({$urandom(), $urandom(), $urandom()}), $urandom_range(0, 9) < thr,
                  $urandom_range(0, 15) == 0);
        end
        idle(12 * NF, 1);
    endtask

`ifdef NET_TX_PARITY_EN
    task automatic test_parity();
        acc.delete();
        idle(2, 1);
        cycle(1, 0, 5'd0, {80{1'b1}}, 1, 0);
        idle(NF + 3, 1);
        checks++;
        if (acc.size() != 7 || acc[6] !== 16'hFFFF) begin
            failures++;
            $display("FAIL parity got=%0d flits last=%h exp=7 ffff", acc.size(),
                     acc.size() > 0 ? acc[acc.size() - 1] : 16'hxxxx);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_status_hdr();
        test_overflow();
        test_toggle_ready();
        test_reset_midframe();
`ifdef NET_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
